// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART receive/transmit buffering.
package uart_pkg;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        RD  = 2'b01,
        WR  = 2'b10,
        RW  = 2'b11
    } fifo_op_t;

    localparam int UART_DBIT       = 8;
    localparam int UART_RX_FIFO_AW = 4;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// Pointer, occupancy and overflow control for a 2^ADDR_WIDTH word queue.
// Optional sticky overflow flag enabled by UART_RX_FIFO_OVF_EN.
//
// op  | meaning
// NOP | hold everything
// RD  | pop head word if not empty
// WR  | push word if not full, else drop it (overflow)
// RW  | push+pop; push only when empty
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_RX_FIFO_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_ptr,
    output logic [ADDR_WIDTH-1:0] r_ptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_LAST = CNT_FULL - 1'b1;

    fifo_op_t              op;
    logic [ADDR_WIDTH-1:0] w_ptr_n, r_ptr_n;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  empty_n, full_n, ovf_set;

    assign op = fifo_op_t'({wr, rd});

    always_comb begin
        w_en    = 1'b0;
        w_ptr_n = w_ptr;
        r_ptr_n = r_ptr;
        count_n = count;
        empty_n = empty;
        full_n  = full;
        ovf_set = 1'b0;
        case (op)
            RD: begin
                if (!empty) begin
                    r_ptr_n = r_ptr + 1'b1;
                    count_n = count - 1'b1;
                    full_n  = 1'b0;
                    empty_n = (count == 1);
                end
            end
            WR: begin
                if (!full) begin
                    w_en    = 1'b1;
                    w_ptr_n = w_ptr + 1'b1;
                    count_n = count + 1'b1;
                    empty_n = 1'b0;
                    full_n  = (count == CNT_LAST);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            RW: begin
                // An empty queue cannot be full, so the write always lands here.
                w_en    = 1'b1;
                w_ptr_n = w_ptr + 1'b1;
                if (empty) begin
                    count_n = count + 1'b1;
                    empty_n = 1'b0;
                    full_n  = (count == CNT_LAST);
                end else begin
                    r_ptr_n = r_ptr + 1'b1;
                end
            end
            default: ;
        endcase
        if (reset) w_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            w_ptr <= w_ptr_n;
            r_ptr <= r_ptr_n;
            count <= count_n;
            empty <= empty_n;
            full  <= full_n;
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset)        ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end
`else
    logic [1:0] unused_ovf;
    assign unused_ovf = {ovf_set, ovf_clr};
    assign ovf        = 1'b0;
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive queue behind the UART receiver.
// Sticky overflow flag present only when UART_RX_FIFO_OVF_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int ADDR_WIDTH = UART_RX_FIFO_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DBIT-1:0]       w_data,
    input  logic                  rd,
    output logic [DBIT-1:0]       r_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DBIT-1:0]       mem [DEPTH];
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;

    uart_fifo_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .ovf_clr (ovf_clr),
        .w_en    (w_en),
        .w_ptr   (w_ptr),
        .r_ptr   (r_ptr),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf)
    );

    // Storage is deliberately left unreset; r_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_en) mem[w_ptr] <= w_data;
    end

    assign r_data = mem[r_ptr];

endmodule
